aes256_ctr_ctrl: RTL and testbench

Sequencer that runs an AES-256 core (init/next/ready/result interface, keylen fixed to 256) in counter mode over a stream of 128-bit blocks. It expands the key once per session and generates one keystream block ahead. Each input block is XORed with the keystream into a registered output, and the counter advances. It sits between the enclave DMA/data path and the shared AES core instance.

---
 rtl/aes256_ctr_ctrl.sv | 146 ++++++++++++++
 tb/tb_aes256_ctr_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_ctr_ctrl.sv
// aes256_ctr_ctrl: AES-256 counter-mode sequencer driving a shared init/next/ready/result core
// Ports: start/cfg_key/cfg_iv open a session; in_* accepts blocks (valid/ready);
// out_* returns in_data ^ keystream (valid/ready); busy/err_wrap report status;
// core_* drive the AES core (one-cycle init/next pulses, key, counter block, ready/result).
module aes256_ctr_ctrl #(
  parameter int CTR_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] cfg_key,
  input  logic [127:0] cfg_iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic         err_wrap,
  output logic         core_init,
  output logic         core_next,
  output logic [255:0] core_key,
  output logic [127:0] core_block,
  input  logic         core_ready,
  input  logic [127:0] core_result
);
  typedef enum logic [2:0] {IDLE, KEY_INIT, KEY_WAIT, GEN, GEN_WAIT, STREAM, HALT} state_t;
  localparam logic [127:0] MASK = (128'd1 << CTR_WIDTH) - 128'd1;
  state_t state_q, state_d;
  logic [255:0] key_q, key_d, sh_key_q, sh_key_d;
  logic [127:0] ctr_q, ctr_d, sh_iv_q, sh_iv_d, ks_q, ks_d, out_data_q, out_data_d;
  logic ks_valid_q, ks_valid_d, out_valid_q, out_valid_d, err_q, err_d;
  logic pend_q, pend_d, skip_q, skip_d;
  logic core_busy, restart, accept;
  assign core_busy  = state_q == KEY_WAIT || state_q == GEN_WAIT;
  // A start while the core is idle restarts immediately; while busy it is deferred
  assign restart    = start && !core_busy;
  assign in_ready   = state_q == STREAM && ks_valid_q && (!out_valid_q || out_ready) && !start;
  assign accept     = in_valid && in_ready;
  // Pulses are suppressed on a start cycle so the core is never kicked into a stale job
  assign core_init  = state_q == KEY_INIT && !start;
  assign core_next  = state_q == GEN && !start;
  assign core_key   = key_q;
  assign core_block = ctr_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = state_q != IDLE;
  assign err_wrap   = err_q;
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    ctr_d       = ctr_q;
    sh_key_d    = sh_key_q;
    sh_iv_d     = sh_iv_q;
    ks_d        = ks_q;
    ks_valid_d  = ks_valid_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    err_d       = err_q;
    pend_d      = pend_q;
    skip_d      = 1'b0;
    case (state_q)
      KEY_INIT: begin
        state_d = KEY_WAIT;
        skip_d  = 1'b1;
      end
      GEN: begin
        state_d = GEN_WAIT;
        skip_d  = 1'b1;
      end
      KEY_WAIT, GEN_WAIT: begin
        if (start) begin
          pend_d   = 1'b1;
          sh_key_d = cfg_key;
          sh_iv_d  = cfg_iv;
        end
        // core_ready is not trusted in the cycle right after a pulse
        if (!skip_q && core_ready) begin
          if (pend_q || start) begin
            key_d       = start ? cfg_key : sh_key_q;
            ctr_d       = start ? cfg_iv : sh_iv_q;
            pend_d      = 1'b0;
            ks_valid_d  = 1'b0;
            out_valid_d = 1'b0;
            err_d       = 1'b0;
            state_d     = KEY_INIT;
          end else if (state_q == KEY_WAIT) begin
            state_d = GEN;
          end else begin
            ks_d       = core_result;
            ks_valid_d = 1'b1;
            state_d    = STREAM;
          end
        end
      end
      STREAM: if (accept) begin
        out_data_d  = in_data ^ ks_q;
        out_valid_d = 1'b1;
        ks_valid_d  = 1'b0;
        ctr_d       = (ctr_q & ~MASK) | ((ctr_q + 128'd1) & MASK);
        err_d       = (ctr_q & MASK) == MASK;
        state_d     = (ctr_q & MASK) == MASK ? HALT : GEN;
      end
      default: ;
    endcase
    if (restart) begin
      key_d       = cfg_key;
      ctr_d       = cfg_iv;
      ks_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      err_d       = 1'b0;
      pend_d      = 1'b0;
      state_d     = KEY_INIT;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      ctr_q       <= '0;
      sh_key_q    <= '0;
      sh_iv_q     <= '0;
      ks_q        <= '0;
      ks_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
      skip_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      ctr_q       <= ctr_d;
      sh_key_q    <= sh_key_d;
      sh_iv_q     <= sh_iv_d;
      ks_q        <= ks_d;
      ks_valid_q  <= ks_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
      skip_q      <= skip_d;
    end
  end
endmodule

// File: tb/tb_aes256_ctr_ctrl.sv
// tb_aes256_ctr_ctrl: directed bench for aes256_ctr_ctrl with a table-driven AES core stand-in
module tb_aes256_ctr_ctrl;
  localparam logic [255:0] K1   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] K2   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] IV1  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] IV1P = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
  localparam logic [127:0] IV2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] IVW  = 128'hf0f1f2f3f4f5f6f7f8f9fafbffffffff;
  localparam logic [127:0] IVWP = 128'hf0f1f2f3f4f5f6f7f8f9fafb00000000;
  localparam logic [127:0] KS1  = 128'h0bdf7df1591716335e9a8b15c860c502;
  localparam logic [127:0] KS2  = 128'h5a6e699d536119065433863c8f657b94;
  localparam logic [127:0] P1   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C1   = 128'h601ec313775789a5b7a7f504bbf3d228;
  localparam logic [127:0] C2   = 128'hf443e3ca4d62b59aca84e990cacaf5c5;
  localparam int LAT = 5;
  int n_cmp = 0, n_bad = 0;
  int n_init = 0, n_next = 0, n_viol = 0, cnt = 0;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [255:0] cfg_key = '0;
  logic [127:0] cfg_iv = '0, in_data = '0;
  logic in_ready, out_valid, busy, err_wrap, core_init, core_next, core_ready;
  logic init_prev = 1'b0, next_prev = 1'b0;
  logic [127:0] out_data, core_block, core_result, res_q;
  logic [255:0] core_key;
  aes256_ctr_ctrl #(.CTR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err_wrap(err_wrap), .core_init(core_init), .core_next(core_next),
    .core_key(core_key), .core_block(core_block), .core_ready(core_ready),
    .core_result(core_result)
  );
  always #5 clk = ~clk;
  function automatic logic [127:0] ks_fn(input logic [255:0] k, input logic [127:0] b);
    if (k == K1 && b == IV1) return KS1;
    if (k == K1 && b == IV1P) return KS2;
    return b ^ k[255:128] ^ k[127:0] ^ 128'hdeadbeef_01234567_89abcdef_cafef00d;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_ready  <= 1'b1;
      cnt         <= 0;
      core_result <= '0;
      res_q       <= '0;
    end else if (core_init || core_next) begin
      core_ready <= 1'b0;
      cnt        <= LAT;
      res_q      <= core_next ? ks_fn(core_key, core_block) : '0;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        core_ready  <= 1'b1;
        core_result <= res_q;
      end
    end
  end
  always @(posedge clk) begin
    init_prev <= core_init;
    next_prev <= core_next;
    if (core_init) n_init <= n_init + 1;
    if (core_next) n_next <= n_next + 1;
    if ((core_init && (init_prev || !core_ready)) || (core_next && (next_prev || !core_ready)))
      n_viol <= n_viol + 1;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic do_start(input logic [255:0] k, input logic [127:0] iv);
    start = 1'b1; cfg_key = k; cfg_iv = iv;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic send(input logic [127:0] d, output bit ok);
    in_valid = 1'b1; in_data = d; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic test_reset;
    n_cmp++;
    if ({in_ready, out_valid, busy, err_wrap} !== 4'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {in_ready, out_valid, busy, err_wrap});
    end
    n_cmp++;
    if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_cmp++;
    if (core_key !== '0 || core_block !== '0) begin
      n_bad++; $display("FAIL reset_core_regs: key %h block %h want 0", core_key, core_block);
    end
    n_cmp++;
    if ({core_init, core_next} !== 2'b0) begin
      n_bad++; $display("FAIL reset_pulses: got %b want 00", {core_init, core_next});
    end
  endtask
  task automatic test_f55;
    bit ok;
    int i0, n0;
    i0 = n_init; n0 = n_next;
    do_start(K1, IV1);
    send(P1, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL f55_accept1: timeout got 0 want 1"); end
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== C1) begin
      n_bad++; $display("FAIL f55_block1: valid %b data %h want 1 %h", out_valid, out_data, C1);
    end
    n_cmp++;
    if (core_block !== IV1P) begin n_bad++; $display("FAIL f55_ctr_inc: got %h want %h", core_block, IV1P); end
    n_cmp++;
    if (core_key !== K1) begin n_bad++; $display("FAIL f55_key: got %h want %h", core_key, K1); end
    send(P2, ok);
    n_cmp++;
    if (!ok || out_data !== C2) begin
      n_bad++; $display("FAIL f55_block2: ok %b data %h want 1 %h", ok, out_data, C2);
    end
    n_cmp++;
    if (n_init - i0 != 1 || n_next - n0 != 2) begin
      n_bad++; $display("FAIL f55_pulse_count: init %0d next %0d want 1 2", n_init - i0, n_next - n0);
    end
  endtask
  task automatic test_backpressure;
    bit ok, bad;
    int n0;
    do_start(K1, IV1);
    n0 = n_next;
    out_ready = 1'b0;
    send(P1, ok);
    n_cmp++;
    if (!ok || out_data !== C1) begin n_bad++; $display("FAIL bp_block1: ok %b data %h want 1 %h", ok, out_data, C1); end
    in_valid = 1'b1; in_data = P2; bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== C1) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin n_bad++; $display("FAIL bp_hold: got instability/in_ready want stable %h, in_ready 0", C1); end
    n_cmp++;
    if (n_next - n0 != 2) begin n_bad++; $display("FAIL bp_prefetch: core_next %0d want 2", n_next - n0); end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== C2) begin
      n_bad++; $display("FAIL bp_block2: valid %b data %h want 1 %h", out_valid, out_data, C2);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask
  task automatic test_wrap;
    bit ok, bad;
    int n0;
    logic [127:0] exp;
    exp = P1 ^ ks_fn(K1, IVW);
    do_start(K1, IVW);
    send(P1, ok);
    n_cmp++;
    if (!ok || out_data !== exp) begin n_bad++; $display("FAIL wrap_block: ok %b data %h want 1 %h", ok, out_data, exp); end
    n_cmp++;
    if (err_wrap !== 1'b1) begin n_bad++; $display("FAIL wrap_err: got %b want 1", err_wrap); end
    n_cmp++;
    if (core_block !== IVWP) begin n_bad++; $display("FAIL wrap_ctr: got %h want %h", core_block, IVWP); end
    n0 = n_next; in_valid = 1'b1; in_data = P2; bad = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || err_wrap !== 1'b1 || busy !== 1'b1) bad = 1'b1;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (bad || n_next != n0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL wrap_halt: bad %b next %0d valid %b want 0 0 0", bad, n_next - n0, out_valid);
    end
    do_start(K1, IV1);
    n_cmp++;
    if (err_wrap !== 1'b0) begin n_bad++; $display("FAIL wrap_clear: got %b want 0", err_wrap); end
    send(P1, ok);
    n_cmp++;
    if (!ok || out_data !== C1) begin n_bad++; $display("FAIL wrap_restart: ok %b data %h want 1 %h", ok, out_data, C1); end
  endtask
  task automatic test_start_gen_wait;
    bit ok, bad;
    int i0;
    do_start(K2, IV2);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (core_next === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL gw_reach_gen: timeout got 0 want 1"); end
    @(negedge clk);
    i0 = n_init;
    do_start(K1, IV1);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (core_ready === 1'b1) break;
      if (core_init !== 1'b0 || n_init != i0) bad = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (bad) begin n_bad++; $display("FAIL gw_init_while_busy: got pulse want none"); end
    n_cmp++;
    if (core_key !== K2) begin n_bad++; $display("FAIL gw_key_shadow: got %h want %h", core_key, K2); end
    send(P1, ok);
    n_cmp++;
    if (!ok || out_data !== C1) begin n_bad++; $display("FAIL gw_new_session: ok %b data %h want 1 %h", ok, out_data, C1); end
    n_cmp++;
    if (n_init - i0 != 1) begin n_bad++; $display("FAIL gw_init_count: got %0d want 1", n_init - i0); end
  endtask
  task automatic test_reset_mid;
    bit ok;
    do_start(K1, IV1);
    out_ready = 1'b0;
    send(P1, ok);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL rm_precond: valid %b busy %b want 1 1", out_valid, busy);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy, err_wrap, core_init, core_next} !== 6'b0 || out_data !== '0 ||
        core_key !== '0 || core_block !== '0) begin
      n_bad++; $display("FAIL rm_async: ctl %b data %h key %h block %h want 0", {in_ready, out_valid, busy,
                        err_wrap, core_init, core_next}, out_data, core_key, core_block);
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    do_start(K1, IV1);
    send(P1, ok);
    n_cmp++;
    if (!ok || out_data !== C1) begin n_bad++; $display("FAIL rm_restart: ok %b data %h want 1 %h", ok, out_data, C1); end
  endtask
  task automatic test_pulses;
    n_cmp++;
    if (n_viol != 0) begin n_bad++; $display("FAIL pulse_rules: violations %0d want 0", n_viol); end
  endtask
  initial begin
    #12;
    test_reset;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_f55;
    test_backpressure;
    test_wrap;
    test_start_gen_wait;
    test_reset_mid;
    repeat (3) @(negedge clk);
    test_pulses;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
